// File: rtl/dac_sample_scheduler_pkg.sv
// Shared types and constants for the DAC sample scheduler and its slot pacer.
package dac_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } sched_state_t;

    localparam int              DAC_W            = 12;
    localparam logic [DAC_W-1:0] DAC_MIDSCALE    = 12'd2048;
    localparam int              TICK_DIV_DEFAULT = 96;

endpackage

// File: rtl/dac_sample_scheduler_slot_tick_gen.sv
// Sample-slot pacer: free-running divider that pulses tick once every TICK_DIV
// cycles while enabled, and parks at zero while disabled.
module slot_tick_gen #(
    parameter int TICK_DIV = dac_sched_pkg::TICK_DIV_DEFAULT
) (
    input  logic clk_100mhz,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    localparam int              CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk_100mhz) begin
        if (rst || !enable) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    assign tick = enable && (count == LAST);

endmodule

// File: rtl/dac_sample_scheduler.sv
// Arbitrates paced DDS samples and host override writes onto a single
// valid/ready channel toward the SPI DAC controller.
module dac_sample_scheduler
    import dac_sched_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT,
    parameter int MISS_W   = 16
) (
    input  logic              clk_100mhz,
    input  logic              rst,
    input  logic              enable,
    input  logic [DAC_W-1:0]  stream_sample,
    input  logic [DAC_W-1:0]  host_code,
    input  logic              host_valid,
    output logic              host_ready,
    output logic [DAC_W-1:0]  dac_code,
    output logic              dac_valid,
    input  logic              dac_ready,
    output logic              sample_tick,
    output logic [MISS_W-1:0] missed_cnt,
    output logic              busy
);

    sched_state_t state;
    sched_state_t state_nxt;
    logic         tick;
    logic         load_code;
    logic         load_host;
    logic         miss;
    logic         src_stream;

    function automatic logic [MISS_W-1:0] sat_inc(input logic [MISS_W-1:0] v);
        return (&v) ? v : v + MISS_W'(1);
    endfunction

    slot_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_pacer (
        .clk_100mhz (clk_100mhz),
        .rst        (rst),
        .enable     (enable),
        .tick       (tick)
    );

    // Host wins a coincident slot; the slot is then consumed without sampling.
    always_comb begin
        state_nxt   = state;
        load_code   = 1'b0;
        load_host   = 1'b0;
        miss        = 1'b0;
        host_ready  = 1'b0;
        sample_tick = 1'b0;
        case (state)
            IDLE: begin
                if (host_valid) begin
                    host_ready = 1'b1;
                    load_code  = 1'b1;
                    load_host  = 1'b1;
                    state_nxt  = SEND;
                end else if (tick) begin
                    load_code = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                miss = tick;
                if (dac_ready) begin
                    sample_tick = src_stream;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // A reset cycle must never look like an acceptance to the host or DDS.
        if (rst) begin
            host_ready  = 1'b0;
            sample_tick = 1'b0;
        end
    end

    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            state      <= IDLE;
            dac_code   <= DAC_MIDSCALE;
            src_stream <= 1'b0;
            missed_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (load_code) begin
                dac_code   <= load_host ? host_code : stream_sample;
                src_stream <= !load_host;
            end
            if (miss) begin
                missed_cnt <= sat_inc(missed_cnt);
            end
        end
    end

    assign dac_valid = (state == SEND);
    assign busy      = (state == SEND);

endmodule
